// File: rtl/mac_array_unit.sv
// Outer-product MAC grid: accumulates a[i]*b[j] over a job of N steps,
// then streams the double-buffered result out one row per cycle.
module mac_array_unit #(
    parameter int MULER_WIDTH  = 8,
    parameter int NUM_WIDTH    = 12,
    parameter int OUTPUT_WIDTH = 32,
    parameter int MULER_DELAY  = 1,
    parameter int ROW_SIZE     = 8,
    parameter int COLUMN_SIZE  = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       num_valid,
    input  logic [NUM_WIDTH-1:0]                       num,
    input  logic [ROW_SIZE-1:0][MULER_WIDTH-1:0]       data_a,
    input  logic [COLUMN_SIZE-1:0][MULER_WIDTH-1:0]    data_b,
    output logic [COLUMN_SIZE-1:0][OUTPUT_WIDTH-1:0]   result_r
);

    localparam int PW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
    localparam int PD = 2 * MULER_WIDTH;

    typedef enum logic {
        JOB_IDLE,
        JOB_RUN
    } job_state_t;

    job_state_t             job_state;
    logic [NUM_WIDTH-1:0]   remaining;
    logic                   first_pending;
    logic                   start;
    logic                   issue;

    logic [PD-1:0] prod_now  [ROW_SIZE][COLUMN_SIZE];
    logic [PD-1:0] prod_pipe [MULER_DELAY][ROW_SIZE][COLUMN_SIZE];
    logic [MULER_DELAY-1:0] tag_v;
    logic [MULER_DELAY-1:0] tag_f;
    logic [MULER_DELAY-1:0] tag_l;

    logic [OUTPUT_WIDTH-1:0] acc     [ROW_SIZE][COLUMN_SIZE];
    logic [OUTPUT_WIDTH-1:0] sum_now [ROW_SIZE][COLUMN_SIZE];
    logic [COLUMN_SIZE-1:0][OUTPUT_WIDTH-1:0] bank [ROW_SIZE];

    logic [PW-1:0] row_ptr;
    logic          streaming;

    assign start = num_valid && (num != '0);
    // A start edge never doubles as a step, even when it aborts a job.
    assign issue = (job_state == JOB_RUN) && !start;

    always_ff @(posedge clk) begin
        if (!rst) begin
            job_state     <= JOB_IDLE;
            remaining     <= '0;
            first_pending <= 1'b0;
        end else if (start) begin
            job_state     <= JOB_RUN;
            remaining     <= num;
            first_pending <= 1'b1;
        end else if (job_state == JOB_RUN) begin
            remaining     <= remaining - NUM_WIDTH'(1);
            first_pending <= 1'b0;
            if (remaining == NUM_WIDTH'(1)) begin
                job_state <= JOB_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_v <= '0;
            tag_f <= '0;
            tag_l <= '0;
        end else begin
            tag_v[0] <= issue;
            tag_f[0] <= issue && first_pending;
            tag_l[0] <= issue && (remaining == NUM_WIDTH'(1));
            for (int s = 1; s < MULER_DELAY; s++) begin
                tag_v[s] <= tag_v[s-1];
                tag_f[s] <= tag_f[s-1];
                tag_l[s] <= tag_l[s-1];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < ROW_SIZE; i++) begin
            for (int j = 0; j < COLUMN_SIZE; j++) begin
                prod_now[i][j] = PD'(data_a[i]) * PD'(data_b[j]);
            end
        end
    end

    // Products carry no reset; the tags alone decide whether they count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ROW_SIZE; i++) begin
            for (int j = 0; j < COLUMN_SIZE; j++) begin
                prod_pipe[0][i][j] <= prod_now[i][j];
                for (int s = 1; s < MULER_DELAY; s++) begin
                    prod_pipe[s][i][j] <= prod_pipe[s-1][i][j];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < ROW_SIZE; i++) begin
            for (int j = 0; j < COLUMN_SIZE; j++) begin
                sum_now[i][j] = OUTPUT_WIDTH'(prod_pipe[MULER_DELAY-1][i][j]);
                if (!tag_f[MULER_DELAY-1]) begin
                    sum_now[i][j] = acc[i][j] + sum_now[i][j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ROW_SIZE; i++) begin
                for (int j = 0; j < COLUMN_SIZE; j++) begin
                    acc[i][j] <= '0;
                end
            end
        end else if (tag_v[MULER_DELAY-1]) begin
            for (int i = 0; i < ROW_SIZE; i++) begin
                for (int j = 0; j < COLUMN_SIZE; j++) begin
                    acc[i][j] <= sum_now[i][j];
                end
            end
        end
    end

    // A fresh bank write always restarts streaming from row 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ROW_SIZE; i++) begin
                bank[i] <= '0;
            end
            row_ptr   <= '0;
            streaming <= 1'b0;
        end else if (tag_v[MULER_DELAY-1] && tag_l[MULER_DELAY-1]) begin
            for (int i = 0; i < ROW_SIZE; i++) begin
                for (int j = 0; j < COLUMN_SIZE; j++) begin
                    bank[i][j] <= sum_now[i][j];
                end
            end
            row_ptr   <= '0;
            streaming <= 1'b1;
        end else if (streaming) begin
            if (row_ptr == PW'(ROW_SIZE - 1)) begin
                streaming <= 1'b0;
            end else begin
                row_ptr <= row_ptr + PW'(1);
            end
        end
    end

    always_comb begin
        result_r = '0;
        if (streaming) begin
            result_r = bank[row_ptr];
        end
    end

endmodule

// File: tb/tb_mac_array_unit.sv
// Scoreboard bench for mac_array_unit: stimulus queues expected rows by
// cycle, a negedge monitor checks every cycle (zero when nothing queued).
module tb_mac_array_unit;

    localparam int R  = 8;
    localparam int C  = 8;
    localparam int MW = 8;
    localparam int NW = 12;
    localparam int OW = 32;
    localparam int D  = 1;

    typedef logic [C-1:0][OW-1:0] row_t;
    typedef logic [R-1:0][MW-1:0] va_t;
    typedef logic [C-1:0][MW-1:0] vb_t;
    typedef struct {
        int unsigned t;
        int          r;
        row_t        row;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          num_valid = 1'b0;
    logic [NW-1:0] num = '0;
    va_t           data_a = '0;
    vb_t           data_b = '0;
    row_t          result_r;

    exp_t        sb[$];
    row_t        exp_m [R];
    int unsigned edge_n = 0;
    int          errors = 0;
    int          checks = 0;
    string       test_name = "reset";

    mac_array_unit #(
        .MULER_WIDTH (MW),
        .NUM_WIDTH   (NW),
        .OUTPUT_WIDTH(OW),
        .MULER_DELAY (D),
        .ROW_SIZE    (R),
        .COLUMN_SIZE (C)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .num_valid(num_valid),
        .num      (num),
        .data_a   (data_a),
        .data_b   (data_b),
        .result_r (result_r)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(negedge clk) begin
        row_t  want;
        string what;
        want = '0;
        what = "idle";
        while (sb.size() > 0 && sb[0].t < edge_n) begin
            checks++;
            errors++;
            $display("FAIL %s missed row %0d at cycle %0d", test_name, sb[0].r, sb[0].t);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].t == edge_n) begin
            want = sb[0].row;
            what = $sformatf("row%0d", sb[0].r);
            void'(sb.pop_front());
        end
        checks++;
        if (result_r !== want) begin
            errors++;
            $display("FAIL %s %s cycle %0d: got %h want %h",
                     test_name, what, edge_n, result_r, want);
        end
    end

    task automatic drive(input logic rv, input logic nv, input logic [NW-1:0] n,
                         input va_t a, input vb_t b);
        @(negedge clk);
        #1;
        rst       = rv;
        num_valid = nv;
        num       = n;
        data_a    = a;
        data_b    = b;
    endtask

    // Called right after the last step is driven; that step lands on edge_n+1.
    task automatic push_rows(input int nrows);
        int unsigned e;
        e = edge_n + 1;
        for (int r = 0; r < nrows; r++) begin
            sb.push_back('{e + D + r, r, exp_m[r]});
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b1, 1'b0, '0, '0, '0);
    endtask

    // Step k of the job-2 pattern: a lanes0-3=1, lanes4-7=k; b one-hot lane k-1.
    task automatic pat_step(input int k);
        va_t a;
        vb_t b;
        for (int i = 0; i < R; i++) a[i] = (i < 4) ? 8'd1 : MW'(k);
        b = '0;
        b[k-1] = 8'd1;
        drive(1'b1, 1'b0, '0, a, b);
    endtask

    initial begin
        va_t a;
        vb_t b;
        va_t a_ff;
        vb_t b_ff;
        int  guard;

        // Test 1: reset held with a start request pending
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, NW'(10), '0, '0);

        // Test 2: N=10 begins on the first edge with rst released
        test_name = "job_n10";
        drive(1'b1, 1'b1, NW'(10), '0, '0);
        for (int k = 1; k <= 8; k++) pat_step(k);
        pat_step(8);
        pat_step(8);
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++)
                exp_m[i][j] = (j < 7) ? ((i < 4) ? 1 : j + 1) : ((i < 4) ? 3 : 24);
        push_rows(R);

        // Test 3: back-to-back N=7
        test_name = "b2b_n7";
        drive(1'b1, 1'b1, NW'(7), '0, '0);
        for (int i = 0; i < R; i++) a[i] = MW'(i + 1);
        b = '0;
        b[0] = 8'd1;
        drive(1'b1, 1'b0, '0, a, b);
        for (int k = 2; k <= 7; k++) pat_step(k);
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++)
                exp_m[i][j] = (j == 0) ? i + 1 : (j == 7) ? 0 : ((i < 4) ? 1 : j + 1);
        push_rows(R);
        idle(12);

        // Test 4: num=0 is ignored, then N=4095 of 255*255
        test_name = "overflow";
        a_ff = '1;
        b_ff = '1;
        drive(1'b1, 1'b1, '0, a_ff, b_ff);
        for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, '0, a_ff, b_ff);
        idle(3);
        drive(1'b1, 1'b1, NW'(4095), '0, '0);
        for (int k = 0; k < 4095; k++) drive(1'b1, 1'b0, '0, a_ff, b_ff);
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++)
                exp_m[i][j] = 32'd266277375;
        push_rows(R);
        idle(12);

        // Test 5: abort an N=10 job after 3 steps with an N=2 job
        test_name = "abort";
        for (int i = 0; i < R; i++) a[i] = 8'd9;
        for (int j = 0; j < C; j++) b[j] = 8'd9;
        drive(1'b1, 1'b1, NW'(10), '0, '0);
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, '0, a, b);
        drive(1'b1, 1'b1, NW'(2), a, b);
        for (int i = 0; i < R; i++) a[i] = MW'(i + 1);
        for (int j = 0; j < C; j++) b[j] = MW'(j + 1);
        drive(1'b1, 1'b0, '0, a, b);
        for (int i = 0; i < R; i++) a[i] = 8'd1;
        for (int j = 0; j < C; j++) b[j] = 8'd1;
        drive(1'b1, 1'b0, '0, a, b);
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++)
                exp_m[i][j] = (i + 1) * (j + 1) + 1;
        push_rows(R);
        idle(12);

        // Test 6: reset lands while row 3 would be streaming
        test_name = "reset_stream";
        drive(1'b1, 1'b1, NW'(8), '0, '0);
        for (int k = 1; k <= 8; k++) pat_step(k);
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++)
                exp_m[i][j] = (j < 7) ? ((i < 4) ? 1 : j + 1) : ((i < 4) ? 1 : 8);
        push_rows(3);
        idle(3);
        for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, '0, '0, '0);
        idle(12);

        guard = 0;
        while (sb.size() > 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d rows still queued, want 0", sb.size());
        end
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
